// File: rtl/shared_dff_register_arbiter.sv
// Round-robin arbiter for one shared WIDTH-bit register used by N_REQ
// requesters. Only the current owner's writes reach the register. A hold
// timer forces a release after MAX_HOLD owned cycles so nobody starves.
//
// Handshake: a requester raises req[i] and keeps it high for as long as it
// wants ownership. gnt[i] rises one edge after the arbiter picks it. While
// gnt[i]=1 the requester may assert wr_en[i]. Dropping req[i] releases the
// register on the next edge. A forced release is flagged by a one-cycle
// timeout pulse. gnt is always one-hot or zero.
module shared_dff_register_arbiter #(
  parameter int               N_REQ     = 4,
  parameter int               WIDTH     = 8,
  parameter int               MAX_HOLD  = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           wr_en,
  input  logic [N_REQ*WIDTH-1:0]     wdata,
  output logic [N_REQ-1:0]           gnt,
  output logic [$clog2(N_REQ)-1:0]   owner_id,
  output logic                       busy,
  output logic [WIDTH-1:0]           q,
  output logic                       timeout,
  output logic                       dbg_state
);

  localparam int IDW = $clog2(N_REQ);
  localparam int HW  = $clog2(MAX_HOLD + 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

  state_t           state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [IDW-1:0]   owner_q;
  logic [IDW-1:0]   rr_q;       // last granted requester; search starts after it
  logic [HW-1:0]    hold_q;     // owned cycles so far, minus one
  logic [WIDTH-1:0] q_q;
  logic             timeout_q;

  logic             win_vld_d;
  logic [IDW-1:0]   win_id_d;

  // Round-robin pick: first set req starting at rr_q+1, wrapping to rr_q last.
  // In OWNED rr_q equals the owner, so a releasing owner (req low) is skipped
  // and a timed-out owner (req high) naturally lands at lowest priority.
  always_comb begin
    win_vld_d = 1'b0;
    win_id_d  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!win_vld_d && req[(int'(rr_q) + k) % N_REQ]) begin
        win_vld_d = 1'b1;
        win_id_d  = IDW'((int'(rr_q) + k) % N_REQ);
      end
    end
  end

  // Ownership FSM, hold timer, timeout pulse and the shared register itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      rr_q      <= IDW'(N_REQ - 1);
      hold_q    <= '0;
      q_q       <= RESET_VAL;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      // The owner's write counts even on its release or timeout edge.
      if (|(gnt_q & wr_en)) begin
        q_q <= wdata[owner_q*WIDTH +: WIDTH];
      end
      case (state_q)
        IDLE: begin
          if (win_vld_d) begin
            state_q <= OWNED;
            gnt_q   <= ONE_HOT0 << win_id_d;
            owner_q <= win_id_d;
            rr_q    <= win_id_d;
            hold_q  <= '0;
          end
        end
        OWNED: begin
          if (!req[owner_q]) begin
            if (win_vld_d) begin
              gnt_q   <= ONE_HOT0 << win_id_d;
              owner_q <= win_id_d;
              rr_q    <= win_id_d;
              hold_q  <= '0;
            end else begin
              state_q <= IDLE;
              gnt_q   <= '0;
              hold_q  <= '0;
            end
          end else if (hold_q == HOLD_LAST) begin
            // Owner still requesting, so win_vld_d is guaranteed here.
            timeout_q <= 1'b1;
            gnt_q     <= ONE_HOT0 << win_id_d;
            owner_q   <= win_id_d;
            rr_q      <= win_id_d;
            hold_q    <= '0;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign owner_id  = owner_q;
  assign busy      = |gnt_q;
  assign q         = q_q;
  assign timeout   = timeout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shared_dff_register_arbiter.sv
// Bench for shared_dff_register_arbiter: directed scenarios plus a random
// soak, all compared against a cycle-level ownership model.
module tb_shared_dff_register_arbiter;

  localparam int N        = 4;
  localparam int W        = 8;
  localparam int MAX_HOLD = 16;
  localparam logic [W-1:0] RST_VAL = 8'h00;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N-1:0]     wr_en = '0;
  logic [N*W-1:0]   wdata = '0;
  logic [N-1:0]     gnt;
  logic [1:0]       owner_id;
  logic             busy;
  logic [W-1:0]     q;
  logic             timeout;
  logic             dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];

  // Model state: owner index (-1 = none), owned-cycle count (1..MAX_HOLD),
  // last granted index, register contents, timeout pulse.
  int           m_owner, m_cnt, m_last;
  logic [W-1:0] m_q;
  logic         m_to;
  int           n_owner, n_cnt, n_last;
  logic [W-1:0] n_q;
  logic         n_to;

  shared_dff_register_arbiter #(
    .N_REQ(N), .WIDTH(W), .MAX_HOLD(MAX_HOLD), .RESET_VAL(RST_VAL)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .wr_en(wr_en), .wdata(wdata),
    .gnt(gnt), .owner_id(owner_id), .busy(busy), .q(q),
    .timeout(timeout), .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(logic [N-1:0] r, int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_last = N - 1; m_q = RST_VAL; m_to = 1'b0;
  endtask

  // Next model state from the inputs presented before the coming edge.
  task automatic model_next();
    n_q = m_q;
    if (m_owner >= 0 && wr_en[m_owner]) n_q = wdata[m_owner*W +: W];
    n_to = 1'b0; n_owner = m_owner; n_cnt = m_cnt; n_last = m_last;
    if (m_owner < 0) begin
      n_owner = pick(req, m_last);
      n_cnt   = 1;
    end else if (!req[m_owner]) begin
      n_owner = pick(req, m_owner);
      n_cnt   = 1;
    end else if (m_cnt == MAX_HOLD) begin
      n_to    = 1'b1;
      n_owner = pick(req, m_owner);
      n_cnt   = 1;
    end else begin
      n_cnt = m_cnt + 1;
    end
    if (n_owner >= 0) n_last = n_owner;
  endtask

  task automatic compare_all();
    logic [N-1:0] eg;
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    check_val("gnt", gnt, eg);
    check_val("busy", busy, m_owner >= 0);
    check_val("state", dbg_state, m_owner >= 0);
    if (m_owner >= 0) check_val("owner_id", owner_id, m_owner);
    check_val("q", q, m_q);
    check_val("timeout", timeout, m_to);
    check_val("onehot", $countones(gnt) <= 1, 1);
  endtask

  // One clock: predict, clock, sample #1 after the edge, compare.
  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    m_owner = n_owner; m_cnt = n_cnt; m_last = n_last; m_q = n_q; m_to = n_to;
    compare_all();
  endtask

  // Asynchronous reset asserted away from the clock edge.
  task automatic do_reset();
    rst = 1'b0;
    #2;
    model_reset();
    check_val("rst_gnt", gnt, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_q", q, RST_VAL);
    check_val("rst_timeout", timeout, 0);
    check_val("rst_owner", owner_id, 0);
    @(posedge clk);
    #1;
    check_val("rst_q_held", q, RST_VAL);
    check_val("rst_gnt_held", gnt, 0);
    req = '0; wr_en = '0;
    rst = 1'b1;
  endtask

  initial begin
    int cyc, last_to, n_to_seen, run;
    logic [N-1:0] prev_gnt;
    bit found;

    @(posedge clk); #1;
    do_reset();

    // Reset mid-ownership with a write pending.
    req = 4'b0001; step();
    wr_en = 4'b0001; wdata[0 +: W] = 8'h5A; step();
    check_val("pre_rst_q", q, 8'h5A);
    wdata[0 +: W] = 8'hEE;
    do_reset();

    // Single requester.
    req = 4'b0100; wr_en = 4'b0100; wdata[2*W +: W] = 8'hA5; step();
    check_val("single_gnt", gnt, 4'b0100);
    req = 4'b0000; step();
    check_val("single_q", q, 8'hA5);
    check_val("single_idle", busy, 0);
    wr_en = '0; step();

    // Round robin with every requester active; each owner holds 2 cycles.
    do_reset();
    for (int g = 0; g < 5; g++) exp_q.push_back(W'(g % N));
    req = 4'b1111; step();
    for (int g = 0; g < 5; g++) begin
      check_val("rr_order", owner_id, exp_q.pop_front());
      check_val("rr_busy", busy, 1);
      step();
      req = 4'b1111 & ~gnt;
      step();
      req = 4'b1111;
    end
    req = '0; step();

    // Non-owner write is ignored, owner write lands.
    do_reset();
    req = 4'b0001; step();
    wr_en = 4'b0010; wdata = '0; wdata[W +: W] = 8'h3C; wdata[0 +: W] = 8'h77; step();
    check_val("nonowner_q", q, RST_VAL);
    wr_en = 4'b0001; wdata[0 +: W] = 8'h11; step();
    check_val("owner_q", q, 8'h11);
    wr_en = '0;

    // Timeout with a lone requester, then a second requester joins.
    do_reset();
    req = 4'b0010; step();
    cyc = 0; last_to = -1; n_to_seen = 0;
    for (int i = 0; i < 50; i++) begin
      step(); cyc++;
      check_val("to_gnt", gnt, 4'b0010);
      if (timeout) begin
        if (last_to >= 0) check_val("to_period", cyc - last_to, MAX_HOLD);
        last_to = cyc; n_to_seen++;
      end
    end
    check_val("to_count", n_to_seen >= 2, 1);
    req = 4'b1010; found = 0;
    for (int i = 0; i < MAX_HOLD + 4 && !found; i++) begin
      step();
      if (timeout) found = 1;
    end
    check_val("to_seen", found, 1);
    check_val("to_move", gnt, 4'b1000);

    // Random soak.
    do_reset();
    run = 0; prev_gnt = '0;
    for (int i = 0; i < 10000; i++) begin
      logic [N-1:0] r;
      for (int b = 0; b < N; b++) r[b] = ($urandom_range(0, 3) != 0);
      if (m_owner >= 0) r[m_owner] = ($urandom_range(0, 15) != 0);
      req   = r;
      wr_en = N'($urandom_range(0, (1 << N) - 1));
      wdata = (N*W)'($urandom);
      step();
      if (busy) run = (gnt == prev_gnt && !timeout) ? run + 1 : 1;
      else run = 0;
      check_val("hold_bound", run <= MAX_HOLD, 1);
      prev_gnt = gnt;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
